// File: rtl/wb_commit.sv
// Architectural-state end of write-back: commits register and PC updates in the WB phase
// and runs the five-phase sequencer of the multi-cycle core.
module wb_commit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [4:0]  Ri_wb,
    input  logic        reg_update,
    input  logic [31:0] reg_new,
    input  logic        pc_update,
    input  logic [31:0] pc_new,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] pc,
    output logic [4:0]  phase,
    output logic        retire,
    output logic [31:0] retired_cnt
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;

    typedef enum logic [4:0] {
        PH_IF  = 5'b00001,
        PH_ID  = 5'b00010,
        PH_EX  = 5'b00100,
        PH_MEM = 5'b01000,
        PH_WB  = 5'b10000
    } phase_t;

    phase_t            state_q;
    phase_t            state_d;
    logic              commit_c;
    logic              reg_wr_c;
    logic [XLEN-1:0]   pc_next_c;
    logic [XLEN-1:0]   regs [NREGS];

    // Phase register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PH_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next phase and commit strobe; illegal encodings fall back to IF regardless of run
    always_comb begin
        state_d  = state_q;
        commit_c = 1'b0;
        case (state_q)
            PH_IF:  if (run) state_d = PH_ID;
            PH_ID:  if (run) state_d = PH_EX;
            PH_EX:  if (run) state_d = PH_MEM;
            PH_MEM: if (run) state_d = PH_WB;
            PH_WB: begin
                if (run) begin
                    state_d  = PH_IF;
                    commit_c = 1'b1;
                end
            end
            default: state_d = PH_IF;
        endcase
    end

    assign reg_wr_c  = commit_c && reg_update && (Ri_wb != 5'd0);
    assign pc_next_c = pc_update ? (pc_new & ~XLEN'(3)) : (pc + XLEN'(PC_STEP));

    // Register file; r0 is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (reg_wr_c) begin
            regs[Ri_wb] <= reg_new;
        end
    end

    // PC, retire pulse and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            retire      <= 1'b0;
            retired_cnt <= '0;
        end else begin
            retire <= commit_c;
            if (commit_c) begin
                pc          <= pc_next_c;
                retired_cnt <= retired_cnt + XLEN'(1);
            end
        end
    end

    assign phase = state_q;

    // Combinational read ports with same-cycle bypass of the committing write
    always_comb begin
        rs_data = regs[rs_addr];
        rt_data = regs[rt_addr];
        if (reg_wr_c && (rs_addr == Ri_wb)) rs_data = reg_new;
        if (reg_wr_c && (rt_addr == Ri_wb)) rt_data = reg_new;
        if (rs_addr == 5'd0) rs_data = '0;
        if (rt_addr == 5'd0) rt_data = '0;
    end

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
- Architectural-state end of the write-back interface: consumes the write-back stage's register-update and PC-update outputs and commits them into the 32x32 register file and the program counter.
- Holds the phase sequencer of the multi-cycle core (IF, ID, EX, MEM, WB).
- Provides the register read ports for decode and the current PC for fetch.
- Commits happen only in the WB phase.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment applied at WB when no PC update is requested.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  phase sequencer advances when 1; all state holds when 0.
- Ri_wb  input  5  destination register index from write-back.
- reg_update  input  1  register write request from write-back.
- reg_new  input  32  register write data.
- pc_update  input  1  PC redirect request from write-back.
- pc_new  input  32  redirect target.
- rs_addr  input  5  read port A index.
- rt_addr  input  5  read port B index.
- rs_data  output  32  read port A data.
- rt_data  output  32  read port B data.
- pc  output  32  current PC.
- phase  output  5  one-hot phase: bit0 IF, bit1 ID, bit2 EX, bit3 MEM, bit4 WB.
- retire  output  1  one-cycle pulse in the cycle after a WB commit.
- retired_cnt  output  32  count of committed instructions.

Behaviour:
- Reset, synchronous and active-high, applied whenever rst=1 at a clock edge, including mid-phase:
  - all 32 registers 0
  - pc=RESET_PC, phase=5'b00001 (IF)
  - retire=0, retired_cnt=0
  - rst has priority over run and over any pending commit.
- Phase sequencer:
  - IF->ID->EX->MEM->WB->IF, one step per clock while run=1.
  - run=0 freezes phase, pc, registers and retired_cnt; retire is forced to 0.
  - phase is always exactly one-hot. Any illegal encoding recovers to IF on the next edge.
- Commit, only at an edge where phase=WB and run=1:
  - Register write: if reg_update=1 and Ri_wb!=0, then regs[Ri_wb]<=reg_new. Writes to r0 are discarded; r0 always reads 0.
  - PC: if pc_update=1, then pc<=pc_new with bits [1:0] forced to 0. Otherwise pc<=pc+PC_STEP, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - retired_cnt<=retired_cnt+1, wrapping at 2^32.
  - retire=1 for exactly the following cycle.
- reg_update, pc_update and Ri_wb are ignored in every phase other than WB.
- Reads are combinational: rs_data=regs[rs_addr], rt_data=regs[rt_addr]; index 0 returns 0.
- Write-through bypass: during the WB phase with run=1, reg_update=1 and Ri_wb!=0, a read port whose address equals Ri_wb returns reg_new in that same cycle.
- Simultaneous register write and PC redirect in the same WB edge are both committed.
- Latency:
  - A write is visible on the read ports from the cycle after the WB edge (same cycle via bypass).
  - The new pc is visible in the IF phase that follows.

Test Plan:
- Reset check: rst=1 for 2 cycles, then run=1 -> pc=RESET_PC, phase=00001, all reads 0; phase steps 00001,00010,00100,01000,10000,00001 over 5 cycles, with pc incrementing by 4 once at the end of WB.
- Register write and bypass: in WB, drive Ri_wb=5, reg_update=1, reg_new=32'hDEADBEEF with rs_addr=5 -> rs_data=DEADBEEF in that cycle (bypass) and in all later cycles; retire pulses once; retired_cnt=1.
- r0 and non-WB protection:
  - Ri_wb=0, reg_update=1, reg_new=32'h1234 in WB -> regs[0] still reads 0.
  - Ri_wb=7, reg_update=1 driven in EX only -> r7 unchanged.
- PC redirect: pc_update=1, pc_new=32'h0000_0103 in WB -> pc=32'h0000_0100 in the next IF. A WB with pc_update=0 at pc=32'hFFFF_FFFC -> pc=0.
- Stall: run=0 for 3 cycles while in MEM with reg_update=1 -> phase stays MEM, no register or pc change, retire=0; run=1 resumes into WB.
- Reset mid-operation: assert rst in the WB phase with reg_update=1, Ri_wb=3, pc_update=1 -> r3=0, pc=RESET_PC, phase=IF, retired_cnt=0, no retire pulse.
